jram_ctl: RTL and testbench

Request/response sequencer upstream of the 256-byte `jRAM` array. It converts a single-beat valid/ready memory request into the `jRAM` strobe sequence: MAR load via `wsa`, then a write via `ws` or a read via `we`. It drives the shared `bio` bus only during writes and returns read data on a held response channel. CPU-side masters, such as a fetch unit or loader, use it instead of toggling `jRAM` strobes directly.

---
 rtl/jram_ctl.sv | 158 +++++++++++++++
 tb/tb_jram_ctl.sv | 264 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/jram_ctl.sv
// jram_ctl: request/response sequencer in front of the 256-byte jRAM array.
//
// Turns a single-beat valid/ready memory request into the jRAM strobe
// sequence (MAR load via wsa, then ws for a write or we for a read) and
// returns the result on a held response channel.
//
// Ports:
//   clk, reset_n          clock, asynchronous active-low reset
//   req_valid/req_ready   request handshake (ready only in idle)
//   req_wr                1 = write, 0 = read
//   req_addr, req_wdata   byte address and write data
//   rsp_valid/rsp_ready   response handshake, response held until taken
//   rsp_rdata             read data (or read-back data in verify builds)
//   rsp_err               write-verify mismatch, 0 unless verify is built in
//   bas, wsa, ws, we      jRAM MAR input and strobes (registered, one-hot)
//   bio                   shared jRAM data bus, driven only while writing
//
// Build option: define JRAM_CTL_VERIFY_EN to follow every write with a
// read-back of the same cell and flag a mismatch on rsp_err.

module jram_ctl (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       req_valid,
    output logic       req_ready,
    input  logic       req_wr,
    input  logic [7:0] req_addr,
    input  logic [7:0] req_wdata,
    output logic       rsp_valid,
    input  logic       rsp_ready,
    output logic [7:0] rsp_rdata,
    output logic       rsp_err,
    output logic [7:0] bas,
    output logic       wsa,
    output logic       ws,
    output logic       we,
    inout  wire  [7:0] bio
);

    typedef enum logic [2:0] {
        StIdle, StSeta, StHolda, StWr, StWrH, StRd, StRdCap, StDone
    } state_e;

    state_e     state_q, state_d;
    logic       armed_q;
    logic       accept;
    logic       wr_q;
    logic [7:0] addr_q, wdata_q;
    logic [7:0] rdata_q;

    // Output registers are loaded from the next state so every strobe comes
    // straight off a flop and lines up with the state it belongs to.
    logic [7:0] bas_q, bas_d;
    logic       wsa_q, wsa_d;
    logic       ws_q, ws_d;
    logic       we_q, we_d;
    logic       drive_q, drive_d;
    logic       valid_q, valid_d;

    // armed_q keeps a request that coincides with reset release from being
    // taken on that same edge.
    assign req_ready = (state_q == StIdle) && armed_q;
    assign accept    = req_valid && req_ready;

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle:  if (accept) state_d = StSeta;
            StSeta:  state_d = StHolda;
            StHolda: state_d = wr_q ? StWr : StRd;
            StWr:    state_d = StWrH;
`ifdef JRAM_CTL_VERIFY_EN
            StWrH:   state_d = StRd;
`else
            StWrH:   state_d = StDone;
`endif
            StRd:    state_d = StRdCap;
            StRdCap: state_d = StDone;
            StDone:  if (rsp_ready) state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    always_comb begin
        bas_d   = 8'h00;
        if (state_d == StSeta) begin
            bas_d = req_addr;  // only reachable from idle on a handshake
        end else if (state_d == StHolda) begin
            bas_d = addr_q;
        end
        wsa_d   = (state_d == StSeta);
        ws_d    = (state_d == StWr);
        we_d    = (state_d == StRd) || (state_d == StRdCap);
        drive_d = (state_d == StWr) || (state_d == StWrH);
        valid_d = (state_d == StDone);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= StIdle;
            armed_q <= 1'b0;
            wr_q    <= 1'b0;
            addr_q  <= 8'h00;
            wdata_q <= 8'h00;
            rdata_q <= 8'h00;
            bas_q   <= 8'h00;
            wsa_q   <= 1'b0;
            ws_q    <= 1'b0;
            we_q    <= 1'b0;
            drive_q <= 1'b0;
            valid_q <= 1'b0;
        end else begin
            state_q <= state_d;
            armed_q <= 1'b1;
            if (accept) begin
                wr_q    <= req_wr;
                addr_q  <= req_addr;
                wdata_q <= req_wdata;
            end
            if (state_q == StRdCap) begin
                rdata_q <= bio;
            end
            bas_q   <= bas_d;
            wsa_q   <= wsa_d;
            ws_q    <= ws_d;
            we_q    <= we_d;
            drive_q <= drive_d;
            valid_q <= valid_d;
        end
    end

`ifdef JRAM_CTL_VERIFY_EN
    logic err_q;

    // A read-back after a write flags a mismatch; a plain read clears it.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            err_q <= 1'b0;
        end else if (state_q == StRdCap) begin
            err_q <= wr_q && (bio != wdata_q);
        end
    end

    assign rsp_err = err_q;
`else
    assign rsp_err = 1'b0;
`endif

    // drive_q is only set in the write states, never while we is high.
    assign bio       = drive_q ? wdata_q : 8'hzz;
    assign bas       = bas_q;
    assign wsa       = wsa_q;
    assign ws        = ws_q;
    assign we        = we_q;
    assign rsp_valid = valid_q;
    assign rsp_rdata = rdata_q;

endmodule

// File: tb/tb_jram_ctl.sv
// Bench for jram_ctl: directed vector table, hand-written corner sequences
// and random transactions checked against a byte-array reference model.
// A small jRAM model sits on the strobe/bus side.

module tb_jram_ctl;

`ifdef JRAM_CTL_VERIFY_EN
    localparam bit VERIFY = 1'b1;
`else
    localparam bit VERIFY = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       reset_n;
    logic       req_valid, req_wr, rsp_ready;
    logic [7:0] req_addr, req_wdata;
    logic       req_ready, rsp_valid, rsp_err;
    logic [7:0] rsp_rdata, bas;
    logic       wsa, ws, we;
    wire  [7:0] bio;

    jram_ctl dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_wr    (req_wr),
        .req_addr  (req_addr),
        .req_wdata (req_wdata),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_rdata (rsp_rdata),
        .rsp_err   (rsp_err),
        .bas       (bas),
        .wsa       (wsa),
        .ws        (ws),
        .we        (we),
        .bio       (bio)
    );

    always #5 clk = ~clk;

    // jRAM model: MAR loads on wsa, cell written on ws, cell driven on we.
    logic [7:0] mem [256];
    logic [7:0] mar;
    bit         mem_init = 1'b0;
    bit         stuck = 1'b0;
    logic [7:0] jram_rd;

    always @(posedge clk) begin
        if (!mem_init) begin
            for (int i = 0; i < 256; i++) mem[i] <= 8'h00;
            mar      <= 8'h00;
            mem_init <= 1'b1;
        end else begin
            if (wsa) mar <= bas;
            if (ws) mem[mar] <= bio;
        end
    end

    assign jram_rd = (stuck && mar == 8'h10) ? 8'h00 : mem[mar];
    assign bio     = we ? jram_rd : 8'hzz;

    // Reference model state.
    logic [7:0] ref_mem [bit [7:0]];
    logic [7:0] last_rd = 8'h00;
    int total = 0;
    int bad = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic chk_ne(input string name, input logic [31:0] act, input logic [31:0] bad_val);
        total++;
        if (act === bad_val) begin
            bad++;
            $display("FAIL %s: got %0h expected anything else at %0t", name, act, $time);
        end
    endtask

    // One transaction, starting at a falling edge with the DUT idle.
    task automatic txn(input bit wr, input logic [7:0] a, input logic [7:0] d, input int hold,
                       output logic [7:0] rd, output logic er);
        int       n, c, exp_lat;
        bit       got;
        logic [2:0] exp_stb;
        n = 0;
        while (!req_ready && n < 20) begin
            @(negedge clk);
            n++;
        end
        chk("req_ready_idle", 32'(req_ready), 32'd1);
        req_valid = 1'b1;
        req_wr    = wr;
        req_addr  = a;
        req_wdata = d;
        @(negedge clk);
        // Junk on the request side must be ignored while busy.
        req_valid = 1'b0;
        req_wr    = 1'($urandom);
        req_addr  = 8'($urandom);
        req_wdata = 8'($urandom);
        exp_lat   = (wr && VERIFY) ? 7 : 5;
        c   = 1;
        got = 1'b0;
        while (!got && c <= 12) begin
            if (rsp_valid) begin
                got = 1'b1;
            end else begin
                exp_stb = {c == 1, wr && c == 3,
                           (!wr && (c == 3 || c == 4)) || (wr && VERIFY && (c == 5 || c == 6))};
                chk("strobes", 32'({wsa, ws, we}), 32'(exp_stb));
                chk("bas", 32'(bas), 32'((c == 1 || c == 2) ? a : 8'h00));
                chk("req_ready_busy", 32'(req_ready), 32'd0);
                if (wr && (c == 3 || c == 4)) begin
                    chk("bio_wdata", 32'(bio), 32'(d));
                end else if (wr && !exp_stb[0] && d != 8'h00) begin
                    chk_ne("bio_released", 32'(bio), 32'(d));
                end
                @(negedge clk);
                c++;
            end
        end
        chk("latency", got ? c : 0, exp_lat);
        chk("done_strobes", 32'({wsa, ws, we}), 32'd0);
        chk("done_bas", 32'(bas), 32'd0);
        chk("done_req_ready", 32'(req_ready), 32'd0);
        rd = rsp_rdata;
        er = rsp_err;
        for (int h = 0; h < hold; h++) begin
            @(negedge clk);
            chk("hold_valid", 32'(rsp_valid), 32'd1);
            chk("hold_rdata", 32'(rsp_rdata), 32'(rd));
            chk("hold_err", 32'(rsp_err), 32'(er));
            chk("hold_strobes", 32'({wsa, ws, we}), 32'd0);
            chk("hold_req_ready", 32'(req_ready), 32'd0);
        end
        rsp_ready = 1'b1;
        @(negedge clk);
        rsp_ready = 1'b0;
        chk("rsp_taken", 32'(rsp_valid), 32'd0);
        chk("back_to_idle", 32'(req_ready), 32'd1);
    endtask

    // Transaction plus reference-model prediction of the response.
    task automatic run(input bit wr, input logic [7:0] a, input logic [7:0] d, input int hold,
                       output logic [7:0] rd);
        logic [7:0] exp_rd, rb;
        logic       er, exp_er;
        txn(wr, a, d, hold, rd, er);
        if (wr) begin
            ref_mem[a] = d;
            rb = (stuck && a == 8'h10) ? 8'h00 : d;
            exp_rd = VERIFY ? rb : last_rd;
            exp_er = VERIFY && (rb != d);
        end else begin
            exp_rd = ref_mem.exists(a) ? ref_mem[a] : 8'h00;
            exp_er = 1'b0;
        end
        chk("rsp_rdata", 32'(rd), 32'(exp_rd));
        chk("rsp_err", 32'(er), 32'(exp_er));
        last_rd = exp_rd;
    endtask

    typedef struct {
        bit         wr;
        logic [7:0] addr;
        logic [7:0] wdata;
        int         hold;
        logic [7:0] exp_rd;  // checked for reads only
    } vec_t;

    vec_t vecs [8];

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin : main
        logic [7:0] rd;
        vecs[0] = '{1'b1, 8'h3C, 8'hA5, 0,  8'h00};
        vecs[1] = '{1'b0, 8'h3C, 8'h00, 0,  8'hA5};
        vecs[2] = '{1'b0, 8'h3C, 8'h11, 10, 8'hA5};
        vecs[3] = '{1'b1, 8'hFF, 8'h00, 0,  8'h00};
        vecs[4] = '{1'b0, 8'hFF, 8'h77, 0,  8'h00};
        vecs[5] = '{1'b1, 8'h01, 8'h7E, 2,  8'h00};
        vecs[6] = '{1'b0, 8'h01, 8'h00, 1,  8'h7E};
        vecs[7] = '{1'b0, 8'h80, 8'h00, 0,  8'h00};

        reset_n   = 1'b0;
        req_valid = 1'b0;
        req_wr    = 1'b0;
        req_addr  = 8'h00;
        req_wdata = 8'h00;
        rsp_ready = 1'b0;

        // Reset held for three cycles.
        repeat (3) @(negedge clk);
        chk("rst_valid", 32'(rsp_valid), 32'd0);
        chk("rst_rdata", 32'(rsp_rdata), 32'd0);
        chk("rst_err", 32'(rsp_err), 32'd0);
        chk("rst_strobes", 32'({wsa, ws, we}), 32'd0);
        chk("rst_bas", 32'(bas), 32'd0);
        reset_n = 1'b1;
        @(negedge clk);
        chk("post_rst_ready", 32'(req_ready), 32'd1);
        chk("post_rst_valid", 32'(rsp_valid), 32'd0);
        chk("post_rst_strobes", 32'({wsa, ws, we}), 32'd0);

        for (int i = 0; i < 8; i++) begin
            run(vecs[i].wr, vecs[i].addr, vecs[i].wdata, vecs[i].hold, rd);
            if (!vecs[i].wr) chk("table_rd", 32'(rd), 32'(vecs[i].exp_rd));
        end

        // Stuck-at-zero cell: only a verified write can notice it.
        stuck = 1'b1;
        run(1'b1, 8'h10, 8'h5A, 0, rd);
        stuck = 1'b0;
        run(1'b0, 8'h10, 8'h00, 0, rd);

        for (int i = 0; i < 40; i++) begin
            run(1'($urandom_range(0, 1)), 8'($urandom_range(0, 31)), 8'($urandom),
                $urandom_range(0, 3), rd);
        end

        // Reset dropped in the middle of WR: strobe and bus must let go at once.
        req_valid = 1'b1;
        req_wr    = 1'b1;
        req_addr  = 8'h44;
        req_wdata = 8'h99;
        @(negedge clk);
        req_valid = 1'b0;
        repeat (2) @(negedge clk);
        chk("mid_ws_high", 32'(ws), 32'd1);
        chk("mid_bio_driven", 32'(bio), 32'h99);
        #2;
        reset_n = 1'b0;
        #1;
        chk("mid_ws_low", 32'(ws), 32'd0);
        chk_ne("mid_bio_released", 32'(bio), 32'h99);
        chk("mid_valid", 32'(rsp_valid), 32'd0);
        chk("mid_bas", 32'(bas), 32'd0);
        chk("mid_rdata", 32'(rsp_rdata), 32'd0);
        repeat (2) @(negedge clk);
        chk("mid_no_rsp", 32'(rsp_valid), 32'd0);
        reset_n = 1'b1;
        last_rd = 8'h00;
        @(negedge clk);
        chk("mid_ready", 32'(req_ready), 32'd1);
        run(1'b0, 8'h3C, 8'h00, 0, rd);
        run(1'b0, 8'h01, 8'h00, 1, rd);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
